multdiv_unit: RTL and testbench

- Multi-cycle signed 32-bit multiply/divide unit in the execute stage, beside the bitwise/arithmetic ALU datapath.
- Consumes the same two operand buses the ALU logic stages receive.
- Its result and ready flag feed the execute-stage result mux and the pipeline stall logic.
- The pipeline stalls from the start pulse until the ready pulse.

---
 rtl/multdiv_pkg.sv | 36 +++
 rtl/multdiv_step_adder.sv | 14 +
 rtl/multdiv_unit.sv | 208 ++++++++++++++++++++
 tb/tb_multdiv_unit.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/multdiv_pkg.sv
// Shared types and iteration counts for multdiv_unit.
// MULTDIV_RADIX4_MULT_EN selects radix-4 Booth multiply (half the multiply iterations).
package multdiv_pkg;

    typedef enum logic [1:0] {
        IDLE,
        MULT,
        DIV,
        DONE
    } state_e;

    typedef enum logic [2:0] {
        NONE,
        ADD,
        SUB,
        ADD2,
        SUB2
    } booth_op_e;

    function automatic int unsigned mult_iters(input int unsigned width);
`ifdef MULTDIV_RADIX4_MULT_EN
        return width / 2;
`else
        return width;
`endif
    endfunction

    function automatic int unsigned div_iters(input int unsigned width);
        return width;
    endfunction

    localparam int unsigned DEF_WIDTH  = 32;
    localparam int unsigned MULT_ITERS = mult_iters(DEF_WIDTH);
    localparam int unsigned DIV_ITERS  = div_iters(DEF_WIDTH);

endpackage

// File: rtl/multdiv_step_adder.sv
// N-bit add/subtract used for both the Booth and the non-restoring step.
// Subtraction is a + ~b + 1, with sub_i acting as the carry-in.
module multdiv_step_adder #(
    parameter int unsigned N = 33
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    input  logic         sub_i,
    output logic [N-1:0] sum_o
);

    assign sum_o = a_i + (b_i ^ {N{sub_i}}) + N'(sub_i);

endmodule

// File: rtl/multdiv_unit.sv
// Multi-cycle signed multiply (Booth) / divide (non-restoring) unit.
// MULTDIV_RADIX4_MULT_EN enables radix-4 Booth multiply; default is radix-2.
module multdiv_unit
    import multdiv_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

`ifdef MULTDIV_RADIX4_MULT_EN
    // Extra guard bit: acc +/- 2M can exceed WIDTH+1 bits in radix-4.
    localparam int unsigned AW = WIDTH + 2;
`else
    localparam int unsigned AW = WIDTH + 1;
`endif
    localparam int unsigned EXT = AW - WIDTH;
    localparam logic [CNT_W-1:0] M_ITERS = CNT_W'(mult_iters(WIDTH));
    localparam logic [CNT_W-1:0] D_ITERS = CNT_W'(div_iters(WIDTH));
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [AW-1:0]    acc_q, acc_d;
    logic [WIDTH-1:0] mq_q, mq_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic             qm1_q, qm1_d;
    logic             neg_q, neg_d;
    logic             dz_q, dz_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             exc_q, exc_d;

    logic             start_mult, start_div;
    logic             last;
    booth_op_e        op;
    logic [AW-1:0]    add_a, add_b, sum;
    logic             add_sub;
    logic [WIDTH-1:0] abs_a, abs_b;

    assign start_mult = ctrl_MULT;
    assign start_div  = ctrl_DIV & ~ctrl_MULT;
    assign last       = (cnt_q == ((state_q == DIV) ? D_ITERS : M_ITERS));
    assign abs_a      = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
    assign abs_b      = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;

    always_ff @(posedge clock) begin
        if (!resetn) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (start_mult) begin
            state_d = MULT;
        end else if (start_div) begin
            state_d = DIV;
        end else begin
            case (state_q)
                MULT, DIV: if (last) state_d = DONE;
                DONE:      state_d = IDLE;
                default:   state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        busy           = (state_q != IDLE);
        data_resultRDY = (state_q == DONE);
    end

    always_comb begin
        op = NONE;
`ifdef MULTDIV_RADIX4_MULT_EN
        case ({mq_q[1:0], qm1_q})
            3'b001, 3'b010: op = ADD;
            3'b011:         op = ADD2;
            3'b100:         op = SUB2;
            3'b101, 3'b110: op = SUB;
            default:        op = NONE;
        endcase
`else
        case ({mq_q[0], qm1_q})
            2'b01:   op = ADD;
            2'b10:   op = SUB;
            default: op = NONE;
        endcase
`endif
    end

    always_comb begin
        add_a   = acc_q;
        add_b   = '0;
        add_sub = 1'b0;
        if (state_q == MULT) begin
            if (op == ADD2 || op == SUB2)
                add_b = {{(EXT-1){opb_q[WIDTH-1]}}, opb_q, 1'b0};
            else if (op != NONE)
                add_b = {{EXT{opb_q[WIDTH-1]}}, opb_q};
            add_sub = (op == SUB || op == SUB2);
        end else if (state_q == DIV) begin
            // Non-restoring: subtract when the partial remainder is non-negative.
            add_a   = {acc_q[AW-2:0], mq_q[WIDTH-1]};
            add_b   = {{EXT{1'b0}}, opb_q};
            add_sub = ~acc_q[AW-1];
        end
    end

    multdiv_step_adder #(.N(AW)) u_step (
        .a_i   (add_a),
        .b_i   (add_b),
        .sub_i (add_sub),
        .sum_o (sum)
    );

    always_comb begin
        cnt_d = cnt_q;
        acc_d = acc_q;
        mq_d  = mq_q;
        opb_d = opb_q;
        qm1_d = qm1_q;
        neg_d = neg_q;
        dz_d  = dz_q;
        ovf_d = ovf_q;
        res_d = res_q;
        exc_d = exc_q;
        if (start_mult || start_div) begin
            cnt_d = '0;
            acc_d = '0;
            qm1_d = 1'b0;
            mq_d  = start_mult ? data_operandA : abs_a;
            opb_d = start_mult ? data_operandB : abs_b;
            neg_d = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            dz_d  = (data_operandB == '0);
            ovf_d = (data_operandA == MIN_VAL) && (data_operandB == '1);
            res_d = '0;
            exc_d = 1'b0;
        end else if (state_q == MULT) begin
            if (!last) begin
                cnt_d = cnt_q + CNT_W'(1);
`ifdef MULTDIV_RADIX4_MULT_EN
                acc_d = {{2{sum[AW-1]}}, sum[AW-1:2]};
                mq_d  = {sum[1:0], mq_q[WIDTH-1:2]};
                qm1_d = mq_q[1];
`else
                acc_d = {sum[AW-1], sum[AW-1:1]};
                mq_d  = {sum[0], mq_q[WIDTH-1:1]};
                qm1_d = mq_q[0];
`endif
            end else begin
                res_d = mq_q;
                exc_d = (acc_q != {AW{mq_q[WIDTH-1]}});
            end
        end else if (state_q == DIV) begin
            if (!last) begin
                cnt_d = cnt_q + CNT_W'(1);
                acc_d = sum;
                mq_d  = {mq_q[WIDTH-2:0], ~sum[AW-1]};
            end else if (dz_q) begin
                res_d = '0;
                exc_d = 1'b1;
            end else begin
                res_d = neg_q ? -mq_q : mq_q;
                exc_d = ovf_q;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            cnt_q <= '0;
            acc_q <= '0;
            mq_q  <= '0;
            opb_q <= '0;
            qm1_q <= 1'b0;
            neg_q <= 1'b0;
            dz_q  <= 1'b0;
            ovf_q <= 1'b0;
            res_q <= '0;
            exc_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            acc_q <= acc_d;
            mq_q  <= mq_d;
            opb_q <= opb_d;
            qm1_q <= qm1_d;
            neg_q <= neg_d;
            dz_q  <= dz_d;
            ovf_q <= ovf_d;
            res_q <= res_d;
            exc_q <= exc_d;
        end
    end

    assign data_result    = res_q;
    assign data_exception = exc_q;

endmodule

// File: tb/tb_multdiv_unit.sv
// Scoreboard bench for multdiv_unit: driver queues expected results, monitor checks on RDY.
module tb_multdiv_unit;

`ifdef MULTDIV_RADIX4_MULT_EN
    localparam int unsigned LAT_M = 17;
`else
    localparam int unsigned LAT_M = 33;
`endif
    localparam int unsigned LAT_D = 33;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic [31:0] op_a = '0, op_b = '0;
    logic        c_mult = 1'b0, c_div = 1'b0;
    logic [31:0] data_result;
    logic        data_exception, data_resultRDY, busy;

    typedef struct {
        logic [31:0] res;
        logic        exc;
        int unsigned start;
        int unsigned lat;
        string       name;
    } exp_t;

    exp_t        sb[$];
    int          errors = 0;
    int          checks = 0;
    int unsigned cyc = 0;

    multdiv_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .clock          (clock),
        .resetn         (resetn),
        .data_operandA  (op_a),
        .data_operandB  (op_b),
        .ctrl_MULT      (c_mult),
        .ctrl_DIV       (c_div),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    always @(negedge clock) begin
        if (data_resultRDY !== 1'b0) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rdy: got rdy=%b at cycle %0d expected no pulse", data_resultRDY, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk({e.name, "_result"}, data_result, e.res);
                chk({e.name, "_exc"}, {31'd0, data_exception}, {31'd0, e.exc});
                chk({e.name, "_latency"}, cyc - e.start, e.lat);
            end
        end
    end

    task automatic start_op(input string name, input bit mult, input bit both,
                            input logic [31:0] av, input logic [31:0] bv,
                            input logic [31:0] er, input bit ee, input bit track);
        exp_t e;
        @(negedge clock);
        op_a   = av;
        op_b   = bv;
        c_mult = mult;
        c_div  = both | ~mult;
        if (track) begin
            e.res = er; e.exc = ee; e.start = cyc + 1;
            e.lat = mult ? LAT_M : LAT_D; e.name = name;
            sb.push_back(e);
        end
        @(negedge clock);
        c_mult = 1'b0;
        c_div  = 1'b0;
        op_a   = $urandom;
        op_b   = $urandom;
        chk({name, "_busy_on_start"}, {31'd0, busy}, 32'd1);
        chk({name, "_cleared_on_start"}, {data_exception, data_result[30:0]}, 32'd0);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clock);
            #1;
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got no rdy after %0d cycles expected rdy", name, n);
            sb.delete();
        end
        @(negedge clock);
        chk({name, "_busy_after_done"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        repeat (3) @(negedge clock);
        chk("reset_result", data_result, 32'd0);
        chk("reset_exc_rdy_busy", {29'd0, data_exception, data_resultRDY, busy}, 32'd0);
        resetn = 1'b1;

        start_op("mul_7x-3", 1, 0, 32'd7, -32'sd3, 32'hFFFF_FFEB, 0, 1);
        wait_idle("mul_7x-3");
        chk("hold_result", data_result, 32'hFFFF_FFEB);

        start_op("mul_ovf", 1, 0, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1, 1);
        wait_idle("mul_ovf");

        start_op("div_-7/2", 0, 0, -32'sd7, 32'd2, 32'hFFFF_FFFD, 0, 1);
        wait_idle("div_-7/2");

        start_op("div_100/-7", 0, 0, 32'd100, -32'sd7, 32'hFFFF_FFF2, 0, 1);
        wait_idle("div_100/-7");

        start_op("div_by_zero", 0, 0, 32'd5, 32'd0, 32'd0, 1, 1);
        wait_idle("div_by_zero");

        start_op("div_min/-1", 0, 0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 1);
        wait_idle("div_min/-1");

        // Divide started, then a multiply restarts the unit 10 edges later.
        start_op("div_aborted", 0, 0, 32'd100, 32'd7, 32'd14, 0, 0);
        repeat (8) @(negedge clock);
        start_op("mul_6x6", 1, 0, 32'd6, 32'd6, 32'd36, 0, 1);
        wait_idle("mul_6x6");

        start_op("mul_reset", 1, 0, 32'd123, 32'd456, 32'd0, 0, 0);
        repeat (5) @(negedge clock);
        resetn = 1'b0;
        @(negedge clock);
        chk("midop_reset_outputs", {28'd0, data_exception, data_resultRDY, busy, |data_result}, 32'd0);
        resetn = 1'b1;
        repeat (40) @(negedge clock);

        start_op("mul_priority", 1, 1, 32'd9, 32'd3, 32'd27, 0, 1);
        wait_idle("mul_priority");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish before time limit");
        $fatal(1);
    end

endmodule
